seven_segment_scan_decoder: RTL and testbench

//  Reads a multiplexed 7-segment display bus (segment lines + one-hot digit select) and recovers the displayed hex value.
//  It is the decode side of our BCD/hex-to-7-segment mapping, used to check display drivers in-system and on the bench.
//  Per-digit dwell is debounced, each pattern is decoded to a nibble, and completed frames are published atomically.

---
 rtl/seven_segment_scan_decoder_pkg.sv | 28 ++
 rtl/seven_segment_codes.vh | 27 ++
 rtl/seven_segment_pattern_decoder.sv | 44 ++++
 rtl/seven_segment_scan_decoder.sv | 162 ++++++++++++++++
 tb/tb_seven_segment_scan_decoder.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seven_segment_scan_decoder_pkg.sv
// rtl/seven_segment_scan_decoder_pkg.sv - types, segment codes and helpers for the scan decoder
//
// Purpose: shared declarations for seven_segment_scan_decoder and its pattern decoder.
//   - segment code localparams (pulled in from seven_segment_codes.vh)
//   - scan_state_e: per-dwell SETTLE/HOLD state
//   - seg_decode_t: decoded result of one segment pattern
//   - is_one_hot(): digit-select legality check
package seven_segment_scan_decoder_pkg;

  `include "seven_segment_codes.vh"

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_HOLD   = 1'b1
  } scan_state_e;

  typedef struct packed {
    logic [3:0] nibble;
    logic       blank;
    logic       err;
  } seg_decode_t;

  // Callers zero-extend their select vector to 32 bits.
  function automatic logic is_one_hot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/seven_segment_codes.vh
// rtl/seven_segment_codes.vh - shared abcdefg segment codes for hex digits and blank
//
// Purpose: the single definition of the hex-to-7-segment mapping. Included by the
// scan decoder package so the encoder side and the decode side read the same table.
// Bit order is a,b,c,d,e,f,g from MSB to LSB; a 1 lights the segment.
`ifndef SEVEN_SEGMENT_CODES_VH
`define SEVEN_SEGMENT_CODES_VH

localparam logic [6:0] SEG_CODE_0     = 7'h7E;
localparam logic [6:0] SEG_CODE_1     = 7'h30;
localparam logic [6:0] SEG_CODE_2     = 7'h6D;
localparam logic [6:0] SEG_CODE_3     = 7'h79;
localparam logic [6:0] SEG_CODE_4     = 7'h33;
localparam logic [6:0] SEG_CODE_5     = 7'h5B;
localparam logic [6:0] SEG_CODE_6     = 7'h5F;
localparam logic [6:0] SEG_CODE_7     = 7'h70;
localparam logic [6:0] SEG_CODE_8     = 7'h7F;
localparam logic [6:0] SEG_CODE_9     = 7'h7B;
localparam logic [6:0] SEG_CODE_A     = 7'h77;
localparam logic [6:0] SEG_CODE_B     = 7'h1F;
localparam logic [6:0] SEG_CODE_C     = 7'h0D;
localparam logic [6:0] SEG_CODE_D     = 7'h3D;
localparam logic [6:0] SEG_CODE_E     = 7'h4F;
localparam logic [6:0] SEG_CODE_F     = 7'h47;
localparam logic [6:0] SEG_CODE_BLANK = 7'h00;

`endif

// File: rtl/seven_segment_pattern_decoder.sv
// rtl/seven_segment_pattern_decoder.sv - combinational abcdefg pattern to hex nibble decoder
//
// Purpose: maps one 7-bit segment pattern back to the hex digit it displays.
// Ports:
//   pattern_i  in  7  segment lines a..g (MSB..LSB), 1 = lit
//   nibble_o   out 4  decoded hex value; 0 for blank or unrecognised patterns
//   blank_o    out 1  pattern was all segments off
//   err_o      out 1  pattern is neither a hex code nor blank
module seven_segment_pattern_decoder
  import seven_segment_scan_decoder_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [3:0] nibble_o,
  output logic       blank_o,
  output logic       err_o
);

  always_comb begin
    nibble_o = 4'h0;
    blank_o  = 1'b0;
    err_o    = 1'b0;
    case (pattern_i)
      SEG_CODE_0:     nibble_o = 4'h0;
      SEG_CODE_1:     nibble_o = 4'h1;
      SEG_CODE_2:     nibble_o = 4'h2;
      SEG_CODE_3:     nibble_o = 4'h3;
      SEG_CODE_4:     nibble_o = 4'h4;
      SEG_CODE_5:     nibble_o = 4'h5;
      SEG_CODE_6:     nibble_o = 4'h6;
      SEG_CODE_7:     nibble_o = 4'h7;
      SEG_CODE_8:     nibble_o = 4'h8;
      SEG_CODE_9:     nibble_o = 4'h9;
      SEG_CODE_A:     nibble_o = 4'hA;
      SEG_CODE_B:     nibble_o = 4'hB;
      SEG_CODE_C:     nibble_o = 4'hC;
      SEG_CODE_D:     nibble_o = 4'hD;
      SEG_CODE_E:     nibble_o = 4'hE;
      SEG_CODE_F:     nibble_o = 4'hF;
      SEG_CODE_BLANK: blank_o  = 1'b1;
      default:        err_o    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_segment_scan_decoder.sv
// rtl/seven_segment_scan_decoder.sv - recovers the hex value shown on a multiplexed 7-segment bus
//
// Purpose: samples segment lines and one-hot digit select, debounces each digit dwell,
// decodes the pattern into a per-digit shadow slot and publishes complete frames atomically.
// Ports:
//   I_CLK        in  1             system clock, rising edge
//   I_RESET      in  1             synchronous active-high reset
//   I_SEGMENTS   in  7             segment lines a..g (MSB..LSB), 1 = lit
//   I_DIGIT_SEL  in  NUM_DIGITS    digit enables, legal only when one-hot
//   O_VALUE      out 4*NUM_DIGITS  last complete frame, nibble i = digit i
//   O_BLANK      out NUM_DIGITS    digit i was blank in the last frame
//   O_DIGIT_ERR  out NUM_DIGITS    digit i held an unrecognised pattern in the last frame
//   O_VALID      out 1             one-cycle pulse when the frame outputs update
module seven_segment_scan_decoder
  import seven_segment_scan_decoder_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                    I_CLK,
  input  logic                    I_RESET,
  input  logic [6:0]              I_SEGMENTS,
  input  logic [NUM_DIGITS-1:0]   I_DIGIT_SEL,
  output logic [4*NUM_DIGITS-1:0] O_VALUE,
  output logic [NUM_DIGITS-1:0]   O_BLANK,
  output logic [NUM_DIGITS-1:0]   O_DIGIT_ERR,
  output logic                    O_VALID
);

  localparam int              CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Input sample and the sample before it.
  logic [6:0]            s_seg_q;
  logic [NUM_DIGITS-1:0] s_sel_q;
  logic [6:0]            p_seg_q;
  logic [NUM_DIGITS-1:0] p_sel_q;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  scan_state_e      state_q, state_d;

  logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0]   shadow_blank_q, shadow_blank_d;
  logic [NUM_DIGITS-1:0]   shadow_err_q, shadow_err_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;

  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   blank_q;
  logic [NUM_DIGITS-1:0]   err_q;
  logic                    valid_q;

  logic        sample_changed;
  logic        sel_one_hot;
  logic        capture;
  logic        frame_full;
  seg_decode_t dec;

  seven_segment_pattern_decoder u_pattern_decoder (
    .pattern_i (s_seg_q),
    .nibble_o  (dec.nibble),
    .blank_o   (dec.blank),
    .err_o     (dec.err)
  );

  // Stability counter: 1 on the first cycle of a new sample, saturating at STABLE_CYCLES.
  always_comb begin
    sample_changed = (s_seg_q != p_seg_q) || (s_sel_q != p_sel_q);
    sel_one_hot    = is_one_hot(32'(s_sel_q));
    if (sample_changed) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Capture fires on the edge where the counter reaches STABLE_CYCLES, so a sample
  // first registered at edge t is captured at edge t+STABLE_CYCLES.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ST_SETTLE: begin
        if ((cnt_d == CNT_MAX) && sel_one_hot) begin
          capture = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (sample_changed) begin
          state_d = ST_SETTLE;
        end
      end
      default: state_d = ST_SETTLE;
    endcase
  end

  // A full mask publishes on the following edge. A capture on that same edge starts
  // the next frame: the mask is cleared first and the new bit is OR-ed in afterwards,
  // while the publish copies the pre-edge shadow.
  always_comb begin
    frame_full     = &mask_q;
    shadow_val_d   = shadow_val_q;
    shadow_blank_d = shadow_blank_q;
    shadow_err_d   = shadow_err_q;
    mask_d         = frame_full ? '0 : mask_q;
    if (capture) begin
      mask_d = mask_d | s_sel_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (s_sel_q[i]) begin
          shadow_val_d[4*i +: 4] = dec.nibble;
          shadow_blank_d[i]      = dec.blank;
          shadow_err_d[i]        = dec.err;
        end
      end
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      s_seg_q        <= '0;
      s_sel_q        <= '0;
      p_seg_q        <= '0;
      p_sel_q        <= '0;
      cnt_q          <= '0;
      state_q        <= ST_SETTLE;
      shadow_val_q   <= '0;
      shadow_blank_q <= '0;
      shadow_err_q   <= '0;
      mask_q         <= '0;
      value_q        <= '0;
      blank_q        <= '0;
      err_q          <= '0;
      valid_q        <= 1'b0;
    end else begin
      s_seg_q        <= I_SEGMENTS;
      s_sel_q        <= I_DIGIT_SEL;
      p_seg_q        <= s_seg_q;
      p_sel_q        <= s_sel_q;
      cnt_q          <= cnt_d;
      state_q        <= state_d;
      shadow_val_q   <= shadow_val_d;
      shadow_blank_q <= shadow_blank_d;
      shadow_err_q   <= shadow_err_d;
      mask_q         <= mask_d;
      valid_q        <= frame_full;
      if (frame_full) begin
        value_q <= shadow_val_q;
        blank_q <= shadow_blank_q;
        err_q   <= shadow_err_q;
      end
    end
  end

  assign O_VALUE     = value_q;
  assign O_BLANK     = blank_q;
  assign O_DIGIT_ERR = err_q;
  assign O_VALID     = valid_q;

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// tb/tb_seven_segment_scan_decoder.sv - self-checking bench for seven_segment_scan_decoder
module tb_seven_segment_scan_decoder;

  localparam int ND = 4;
  localparam int SC = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    seg;
  logic [ND-1:0] sel;
  logic [15:0]   o_value;
  logic [3:0]    o_blank;
  logic [3:0]    o_err;
  logic          o_valid;

  seven_segment_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .I_CLK       (clk),
    .I_RESET     (rst),
    .I_SEGMENTS  (seg),
    .I_DIGIT_SEL (sel),
    .O_VALUE     (o_value),
    .O_BLANK     (o_blank),
    .O_DIGIT_ERR (o_err),
    .O_VALID     (o_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic [15:0] fr_val[$];
  logic [3:0]  fr_blank[$];
  logic [3:0]  fr_err[$];
  int          fr_cyc[$];

  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      fr_val.push_back(o_value);
      fr_blank.push_back(o_blank);
      fr_err.push_back(o_err);
      fr_cyc.push_back(cyc);
    end
  end

  typedef struct {
    logic [6:0] pat;
    logic [3:0] nib;
    logic       blank;
    logic       err;
  } vec_t;

  vec_t vecs[19];
  logic [6:0] hex_codes[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic dwell(input logic [6:0] s, input logic [3:0] d, input int n);
    seg = s;
    sel = d;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    seg = '0;
    sel = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_frame(input string name, input int idx, input logic [15:0] v,
                             input logic [3:0] b, input logic [3:0] e);
    if (fr_val.size() > idx) begin
      check(name, {8'h0, fr_val[idx], fr_blank[idx], fr_err[idx]}, {8'h0, v, b, e});
    end else begin
      check({name, "_present"}, 32'(fr_val.size()), 32'(idx + 1));
    end
  endtask

  // Reference decode: search the hex table, otherwise blank or error.
  function automatic logic [5:0] model_decode(input logic [6:0] p);
    for (int k = 0; k < 16; k++) begin
      if (hex_codes[k] == p) return {4'(k), 1'b0, 1'b0};
    end
    if (p == 7'h00) return {4'h0, 1'b1, 1'b0};
    return {4'h0, 1'b0, 1'b1};
  endfunction

  initial begin
    int base;
    int start3;
    hex_codes = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                  7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h0D, 7'h3D, 7'h4F, 7'h47};
    vecs[0]  = '{7'h7E, 4'h0, 1'b0, 1'b0};
    vecs[1]  = '{7'h30, 4'h1, 1'b0, 1'b0};
    vecs[2]  = '{7'h6D, 4'h2, 1'b0, 1'b0};
    vecs[3]  = '{7'h79, 4'h3, 1'b0, 1'b0};
    vecs[4]  = '{7'h33, 4'h4, 1'b0, 1'b0};
    vecs[5]  = '{7'h5B, 4'h5, 1'b0, 1'b0};
    vecs[6]  = '{7'h5F, 4'h6, 1'b0, 1'b0};
    vecs[7]  = '{7'h70, 4'h7, 1'b0, 1'b0};
    vecs[8]  = '{7'h7F, 4'h8, 1'b0, 1'b0};
    vecs[9]  = '{7'h7B, 4'h9, 1'b0, 1'b0};
    vecs[10] = '{7'h77, 4'hA, 1'b0, 1'b0};
    vecs[11] = '{7'h1F, 4'hB, 1'b0, 1'b0};
    vecs[12] = '{7'h0D, 4'hC, 1'b0, 1'b0};
    vecs[13] = '{7'h3D, 4'hD, 1'b0, 1'b0};
    vecs[14] = '{7'h4F, 4'hE, 1'b0, 1'b0};
    vecs[15] = '{7'h47, 4'hF, 1'b0, 1'b0};
    vecs[16] = '{7'h00, 4'h0, 1'b1, 1'b0};
    vecs[17] = '{7'h01, 4'h0, 1'b0, 1'b1};
    vecs[18] = '{7'h7C, 4'h0, 1'b0, 1'b1};

    // Reset state
    do_reset();
    check("reset_value", 32'(o_value), 32'h0);
    check("reset_blank", 32'(o_blank), 32'h0);
    check("reset_err", 32'(o_err), 32'h0);
    check("reset_valid", 32'(o_valid), 32'h0);
    dwell(7'h00, 4'b0000, 40);
    check("reset_no_valid", 32'(fr_val.size()), 32'h0);

    // Clean scan with latency check
    base = fr_val.size();
    dwell(7'h30, 4'b0001, 20);
    dwell(7'h6D, 4'b0010, 20);
    dwell(7'h79, 4'b0100, 20);
    start3 = cyc + 1;
    dwell(7'h33, 4'b1000, 20);
    dwell(7'h00, 4'b0000, 5);
    check("clean_count", 32'(fr_val.size()), 32'(base + 1));
    check_frame("clean_frame", base, 16'h4321, 4'h0, 4'h0);
    if (fr_cyc.size() > base) check("clean_latency", 32'(fr_cyc[base] - start3), 32'd17);

    // Decode table: every digit shows the same pattern
    for (int r = 0; r < 19; r++) begin
      base = fr_val.size();
      for (int d = 0; d < ND; d++) dwell(vecs[r].pat, 4'(1 << d), 20);
      dwell(7'h00, 4'b0000, 3);
      check($sformatf("table_count_%0d", r), 32'(fr_val.size()), 32'(base + 1));
      check_frame($sformatf("table_frame_%0d", r), base, {4{vecs[r].nib}},
                  {4{vecs[r].blank}}, {4{vecs[r].err}});
    end

    // Debounce
    do_reset();
    base = fr_val.size();
    dwell(7'h6D, 4'b0010, 20);
    dwell(7'h79, 4'b0100, 20);
    dwell(7'h33, 4'b1000, 20);
    for (int k = 0; k < 6; k++) dwell((k % 2) ? 7'h6D : 7'h30, 4'b0001, 10);
    dwell(7'h00, 4'b0000, 5);
    check("debounce_toggle", 32'(fr_val.size()), 32'(base));
    dwell(7'h7F, 4'b0001, 15);
    dwell(7'h00, 4'b0000, 5);
    check("debounce_15", 32'(fr_val.size()), 32'(base));
    dwell(7'h5B, 4'b0001, 16);
    dwell(7'h00, 4'b0000, 5);
    check("debounce_16_count", 32'(fr_val.size()), 32'(base + 1));
    check_frame("debounce_16_frame", base, 16'h4325, 4'h0, 4'h0);

    // Ghosting: multi-hot and zero selects must not set mask bits
    do_reset();
    base = fr_val.size();
    for (int k = 0; k < 2; k++) begin
      dwell(7'h7F, 4'b0011, 100);
      dwell(7'h7F, 4'b0000, 30);
    end
    dwell(7'h79, 4'b0100, 20);
    dwell(7'h5F, 4'b1000, 20);
    dwell(7'h00, 4'b0000, 10);
    check("ghost_no_frame", 32'(fr_val.size()), 32'(base));
    dwell(7'h4F, 4'b0001, 20);
    dwell(7'h47, 4'b0010, 20);
    dwell(7'h00, 4'b0000, 5);
    check("ghost_count", 32'(fr_val.size()), 32'(base + 1));
    check_frame("ghost_frame", base, 16'h63FE, 4'h0, 4'h0);

    // Blank and bad patterns
    do_reset();
    base = fr_val.size();
    dwell(7'h30, 4'b0001, 20);
    dwell(7'h01, 4'b0010, 20);
    dwell(7'h00, 4'b0100, 20);
    dwell(7'h79, 4'b1000, 20);
    dwell(7'h00, 4'b0000, 5);
    check("badblank_count", 32'(fr_val.size()), 32'(base + 1));
    check_frame("badblank_frame", base, 16'h3001, 4'b0100, 4'b0010);

    // Reset mid-frame, new scan starts with the digit that would complete the stale mask
    dwell(7'h30, 4'b0001, 20);
    dwell(7'h6D, 4'b0010, 20);
    dwell(7'h79, 4'b0100, 20);
    do_reset();
    check("midreset_value", 32'(o_value), 32'h0);
    check("midreset_flags", 32'({o_blank, o_err}), 32'h0);
    base = fr_val.size();
    dwell(7'h0D, 4'b1000, 20);
    dwell(7'h7B, 4'b0001, 20);
    dwell(7'h77, 4'b0010, 20);
    dwell(7'h1F, 4'b0100, 20);
    dwell(7'h00, 4'b0000, 5);
    check("midreset_count", 32'(fr_val.size()), 32'(base + 1));
    check_frame("midreset_frame", base, 16'hCBA9, 4'h0, 4'h0);

    // Randomized dwells against a frame-level model
    begin
      logic [6:0]  prev_s;
      logic [3:0]  prev_d;
      logic [6:0]  s;
      logic [3:0]  d;
      int          len;
      int          r;
      logic [3:0]  m_mask;
      logic [15:0] m_val;
      logic [3:0]  m_blank;
      logic [3:0]  m_err;
      logic [5:0]  dc;
      logic [15:0] e_val[$];
      logic [3:0]  e_blank[$];
      logic [3:0]  e_err[$];
      do_reset();
      base    = fr_val.size();
      prev_s  = 7'h00;
      prev_d  = 4'h0;
      m_mask  = 4'h0;
      m_val   = 16'h0;
      m_blank = 4'h0;
      m_err   = 4'h0;
      for (int n = 0; n < 200; n++) begin
        do begin
          r = $urandom_range(0, 9);
          if (r < 7) d = 4'(1 << $urandom_range(0, 3));
          else if (r == 7) d = 4'h0;
          else begin
            do d = 4'($urandom_range(0, 15)); while ($countones(d) < 2);
          end
          r = $urandom_range(0, 9);
          if (r < 6) s = hex_codes[$urandom_range(0, 15)];
          else if (r == 6) s = 7'h00;
          else s = 7'($urandom_range(0, 127));
        end while (s == prev_s && d == prev_d);
        len = $urandom_range(8, 30);
        dwell(s, d, len);
        if (len >= SC && $countones(d) == 1) begin
          dc = model_decode(s);
          for (int i = 0; i < ND; i++) begin
            if (d[i]) begin
              m_val[4*i +: 4] = dc[5:2];
              m_blank[i]      = dc[1];
              m_err[i]        = dc[0];
            end
          end
          m_mask = m_mask | d;
          if (m_mask == 4'hF) begin
            e_val.push_back(m_val);
            e_blank.push_back(m_blank);
            e_err.push_back(m_err);
            m_mask = 4'h0;
          end
        end
        prev_s = s;
        prev_d = d;
      end
      dwell(7'h00, 4'b0000, 5);
      check("random_count", 32'(fr_val.size() - base), 32'(e_val.size()));
      for (int i = 0; i < e_val.size(); i++) begin
        check_frame($sformatf("random_frame_%0d", i), base + i, e_val[i], e_blank[i], e_err[i]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
